// File: rtl/decode_block_if.sv
// Bundle between upstream issue, downstream write-back and the
// execution stage for decode_block.
interface decode_block_if;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        wb_en;
   logic [2:0]  wb_addr;
   logic [7:0]  wb_data;
   logic [7:0]  A;
   logic [7:0]  B;
   logic [4:0]  op_dec;
   logic [2:0]  rd_dec;
   logic        valid_dec;

   modport master (
      output instr, instr_valid,
      output wb_en, wb_addr, wb_data,
      input  instr_ready,
      input  A, B, op_dec, rd_dec, valid_dec
   );

   modport slave (
      input  instr, instr_valid,
      input  wb_en, wb_addr, wb_data,
      output instr_ready,
      output A, B, op_dec, rd_dec, valid_dec
   );
endinterface

// File: rtl/decode_block.sv
// Decode / operand-fetch stage: 8x8 register file with write-back
// bypass and a per-register RAW scoreboard gating issue.
module decode_block (
   input  logic          clk,
   input  logic          reset,
   decode_block_if.slave bus
);

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } sb_state_t;

   sb_state_t sb_q [8];
   sb_state_t sb_d [8];
   logic [7:0] rf [8];

   logic [4:0] opc;
   logic [2:0] rd;
   logic [2:0] rs;
   logic       imm_sel;
   logic       writes_rd;
   logic       hit_a;
   logic       hit_b;
   logic       blk_a;
   logic       blk_b;
   logic       ready;
   logic       accept;
   logic [7:0] val_a;
   logic [7:0] val_b;

   logic [7:0] a_q;
   logic [7:0] b_q;
   logic [4:0] op_q;
   logic [2:0] rd_q;
   logic       v_q;

   assign opc     = bus.instr[15:11];
   assign rd      = bus.instr[10:8];
   assign rs      = bus.instr[2:0];
   assign imm_sel = bus.instr[15];

   assign writes_rd = (opc != 5'b00000)
                   && (opc[4:3] != 2'b11);

   // A write-back landing this cycle both bypasses and unblocks
   assign hit_a = bus.wb_en && (bus.wb_addr == rd);
   assign hit_b = bus.wb_en && (bus.wb_addr == rs);

   assign blk_a = (sb_q[rd] == PENDING) && !hit_a;
   assign blk_b = !imm_sel
               && (sb_q[rs] == PENDING) && !hit_b;

   assign ready  = !blk_a && !blk_b;
   assign accept = bus.instr_valid && ready;

   assign val_a = hit_a ? bus.wb_data : rf[rd];
   assign val_b = imm_sel ? bus.instr[7:0]
                : hit_b   ? bus.wb_data
                :           rf[rs];

   // Issue set takes priority over a same-index write-back clear
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         sb_d[i] = sb_q[i];
         if (accept && writes_rd && (rd == 3'(i)))
            sb_d[i] = PENDING;
         else if (bus.wb_en && (bus.wb_addr == 3'(i)))
            sb_d[i] = IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++)
            sb_q[i] <= IDLE;
      end else begin
         for (int i = 0; i < 8; i++)
            sb_q[i] <= sb_d[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++)
            rf[i] <= 8'h00;
      end else if (bus.wb_en) begin
         rf[bus.wb_addr] <= bus.wb_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q  <= 8'h00;
         b_q  <= 8'h00;
         op_q <= 5'b00000;
         rd_q <= 3'd0;
         v_q  <= 1'b0;
      end else if (accept) begin
         a_q  <= val_a;
         b_q  <= val_b;
         op_q <= opc;
         rd_q <= rd;
         v_q  <= 1'b1;
      end else begin
         a_q  <= 8'h00;
         b_q  <= 8'h00;
         op_q <= 5'b00000;
         rd_q <= 3'd0;
         v_q  <= 1'b0;
      end
   end

   assign bus.instr_ready = ready;
   assign bus.A           = a_q;
   assign bus.B           = b_q;
   assign bus.op_dec      = op_q;
   assign bus.rd_dec      = rd_q;
   assign bus.valid_dec   = v_q;

endmodule

// File: tb/tb_decode_block.sv
// Self-checking bench for decode_block: scoreboard of expected
// decode outputs, one task per scenario.
module tb_decode_block;

   logic clk = 1'b0;
   logic reset = 1'b0;

   decode_block_if ifc ();

   decode_block dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [4:0] op;
      logic [2:0] rd;
      logic       v;
   } out_t;

   typedef struct {
      bit          v;
      logic [15:0] i;
      bit          we;
      logic [2:0]  wa;
      logic [7:0]  wd;
      logic        rdy;
      out_t        e;
   } step_t;

   localparam out_t BUB = '0;

   out_t exp_q [$];
   int n_run  = 0;
   int n_fail = 0;

   function automatic logic [15:0] mk(logic [4:0] op,
                                      logic [2:0] rd,
                                      logic [7:0] f);
      return {op, rd, f};
   endfunction

   function automatic out_t ex(logic [7:0] a, logic [7:0] b,
                               logic [4:0] op, logic [2:0] rd);
      return {a, b, op, rd, 1'b1};
   endfunction

   function automatic step_t S(bit v, logic [15:0] i, bit we,
                               logic [2:0] wa, logic [7:0] wd,
                               logic rdy, out_t e);
      step_t s;
      s.v = v; s.i = i; s.we = we; s.wa = wa; s.wd = wd;
      s.rdy = rdy; s.e = e;
      return s;
   endfunction

   function automatic out_t obs();
      return {ifc.A, ifc.B, ifc.op_dec, ifc.rd_dec, ifc.valid_dec};
   endfunction

   task automatic drive(bit v, logic [15:0] i, bit we,
                        logic [2:0] wa, logic [7:0] wd);
      @(negedge clk);
      ifc.instr_valid = v;
      ifc.instr       = i;
      ifc.wb_en       = we;
      ifc.wb_addr     = wa;
      ifc.wb_data     = wd;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      ifc.instr_valid = 1'b0;
      ifc.instr = '0;
      ifc.wb_en = 1'b0;
      ifc.wb_addr = '0;
      ifc.wb_data = '0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      out_t e;
      ifc.instr_valid = 1'b0;
      ifc.instr = '0;
      ifc.wb_en = 1'b0;
      ifc.wb_addr = '0;
      ifc.wb_data = '0;
      reset = 1'b1;
      tick();
      n_run++;
      if (obs() !== BUB) begin
         n_fail++;
         $display("FAIL rst_init out got %h want %h", obs(), BUB);
      end
      n_run++;
      if (ifc.instr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_init ready got %b want 1", ifc.instr_ready);
      end
      @(negedge clk);
      reset = 1'b0;
      // RF[3] = 0x5A, then issue rd=3 so pending[3] = 1
      drive(1'b0, 16'h0000, 1'b1, 3'd3, 8'h5A);
      tick();
      e = exp_q.size() != 0 ? exp_q.pop_front() : BUB;
      n_run++;
      if (obs() !== e) begin
         n_fail++;
         $display("FAIL rst_wb out got %h want %h", obs(), e);
      end
      drive(1'b1, mk(5'd1, 3'd3, 8'h00), 1'b0, 3'd0, 8'h00);
      exp_q.push_back(ex(8'h5A, 8'h00, 5'd1, 3'd3));
      tick();
      e = exp_q.size() != 0 ? exp_q.pop_front() : BUB;
      n_run++;
      if (obs() !== e) begin
         n_fail++;
         $display("FAIL rst_pre out got %h want %h", obs(), e);
      end
      // Mid-cycle async reset with a write-back in flight
      drive(1'b1, mk(5'd2, 3'd3, 8'h00), 1'b1, 3'd3, 8'h77);
      reset = 1'b1;
      #1;
      n_run++;
      if (obs() !== BUB) begin
         n_fail++;
         $display("FAIL rst_async out got %h want %h", obs(), BUB);
      end
      tick();
      reset = 1'b0;
      drive(1'b1, mk(5'd1, 3'd3, 8'h03), 1'b0, 3'd0, 8'h00);
      n_run++;
      if (ifc.instr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_ready got %b want 1", ifc.instr_ready);
      end
      exp_q.push_back(ex(8'h00, 8'h00, 5'd1, 3'd3));
      tick();
      e = exp_q.size() != 0 ? exp_q.pop_front() : BUB;
      n_run++;
      if (obs() !== e) begin
         n_fail++;
         $display("FAIL rst_rf3 out got %h want %h", obs(), e);
      end
   endtask

   task automatic test_wb_read();
      step_t st [$];
      out_t e;
      do_reset();
      st.push_back(S(0, 16'h0000, 1, 3'd2, 8'h11, 1, BUB));
      st.push_back(S(0, 16'h0000, 1, 3'd5, 8'h22, 1, BUB));
      st.push_back(S(1, mk(5'd1, 3'd2, 8'h05), 0, 3'd0, 8'h00, 1,
                     ex(8'h11, 8'h22, 5'd1, 3'd2)));
      foreach (st[k]) begin
         drive(st[k].v, st[k].i, st[k].we, st[k].wa, st[k].wd);
         n_run++;
         if (ifc.instr_ready !== st[k].rdy) begin
            n_fail++;
            $display("FAIL wb_read[%0d] ready got %b want %b",
                     k, ifc.instr_ready, st[k].rdy);
         end
         if (st[k].v && st[k].rdy) exp_q.push_back(st[k].e);
         tick();
         e = exp_q.size() != 0 ? exp_q.pop_front() : BUB;
         n_run++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL wb_read[%0d] out got %h want %h", k, obs(), e);
         end
      end
   endtask

   task automatic test_imm();
      step_t st [$];
      out_t e;
      do_reset();
      st.push_back(S(0, 16'h0000, 1, 3'd1, 8'h3C, 1, BUB));
      st.push_back(S(1, mk(5'b10010, 3'd1, 8'hC3), 0, 3'd0, 8'h00, 1,
                     ex(8'h3C, 8'hC3, 5'b10010, 3'd1)));
      foreach (st[k]) begin
         drive(st[k].v, st[k].i, st[k].we, st[k].wa, st[k].wd);
         n_run++;
         if (ifc.instr_ready !== st[k].rdy) begin
            n_fail++;
            $display("FAIL imm[%0d] ready got %b want %b",
                     k, ifc.instr_ready, st[k].rdy);
         end
         if (st[k].v && st[k].rdy) exp_q.push_back(st[k].e);
         tick();
         e = exp_q.size() != 0 ? exp_q.pop_front() : BUB;
         n_run++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL imm[%0d] out got %h want %h", k, obs(), e);
         end
      end
   endtask

   task automatic test_raw();
      step_t st [$];
      out_t e;
      do_reset();
      st.push_back(S(1, mk(5'd1, 3'd4, 8'h00), 0, 3'd0, 8'h00, 1,
                     ex(8'h00, 8'h00, 5'd1, 3'd4)));
      // Immediate form: field[2:0]=4 is not a source
      st.push_back(S(1, mk(5'b10000, 3'd5, 8'h04), 0, 3'd0, 8'h00, 1,
                     ex(8'h00, 8'h04, 5'b10000, 3'd5)));
      st.push_back(S(1, mk(5'd2, 3'd4, 8'h00), 0, 3'd0, 8'h00, 0, BUB));
      st.push_back(S(1, mk(5'd2, 3'd4, 8'h00), 1, 3'd3, 8'h33, 0, BUB));
      st.push_back(S(1, mk(5'd2, 3'd4, 8'h00), 0, 3'd0, 8'h00, 0, BUB));
      st.push_back(S(1, mk(5'd2, 3'd4, 8'h00), 1, 3'd4, 8'h7E, 1,
                     ex(8'h7E, 8'h00, 5'd2, 3'd4)));
      foreach (st[k]) begin
         drive(st[k].v, st[k].i, st[k].we, st[k].wa, st[k].wd);
         n_run++;
         if (ifc.instr_ready !== st[k].rdy) begin
            n_fail++;
            $display("FAIL raw[%0d] ready got %b want %b",
                     k, ifc.instr_ready, st[k].rdy);
         end
         if (st[k].v && st[k].rdy) exp_q.push_back(st[k].e);
         tick();
         e = exp_q.size() != 0 ? exp_q.pop_front() : BUB;
         n_run++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL raw[%0d] out got %h want %h", k, obs(), e);
         end
      end
   endtask

   task automatic test_store();
      step_t st [$];
      out_t e;
      do_reset();
      st.push_back(S(0, 16'h0000, 1, 3'd6, 8'h66, 1, BUB));
      st.push_back(S(1, mk(5'b11000, 3'd6, 8'h00), 0, 3'd0, 8'h00, 1,
                     ex(8'h66, 8'h00, 5'b11000, 3'd6)));
      st.push_back(S(1, mk(5'd1, 3'd0, 8'h06), 0, 3'd0, 8'h00, 1,
                     ex(8'h00, 8'h66, 5'd1, 3'd0)));
      foreach (st[k]) begin
         drive(st[k].v, st[k].i, st[k].we, st[k].wa, st[k].wd);
         n_run++;
         if (ifc.instr_ready !== st[k].rdy) begin
            n_fail++;
            $display("FAIL store[%0d] ready got %b want %b",
                     k, ifc.instr_ready, st[k].rdy);
         end
         if (st[k].v && st[k].rdy) exp_q.push_back(st[k].e);
         tick();
         e = exp_q.size() != 0 ? exp_q.pop_front() : BUB;
         n_run++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL store[%0d] out got %h want %h", k, obs(), e);
         end
      end
   endtask

   task automatic test_set_clear();
      step_t st [$];
      out_t e;
      do_reset();
      st.push_back(S(1, mk(5'd1, 3'd1, 8'h00), 0, 3'd0, 8'h00, 1,
                     ex(8'h00, 8'h00, 5'd1, 3'd1)));
      st.push_back(S(1, mk(5'd1, 3'd0, 8'h01), 1, 3'd1, 8'h9D, 1,
                     ex(8'h00, 8'h9D, 5'd1, 3'd0)));
      st.push_back(S(1, mk(5'd1, 3'd2, 8'h01), 0, 3'd0, 8'h00, 1,
                     ex(8'h00, 8'h9D, 5'd1, 3'd2)));
      st.push_back(S(1, mk(5'd1, 3'd3, 8'h00), 0, 3'd0, 8'h00, 0, BUB));
      // Same-index issue and write-back: set must win
      st.push_back(S(1, mk(5'd1, 3'd0, 8'h00), 1, 3'd0, 8'h44, 1,
                     ex(8'h44, 8'h44, 5'd1, 3'd0)));
      st.push_back(S(1, mk(5'd1, 3'd5, 8'h00), 0, 3'd0, 8'h00, 0, BUB));
      foreach (st[k]) begin
         drive(st[k].v, st[k].i, st[k].we, st[k].wa, st[k].wd);
         n_run++;
         if (ifc.instr_ready !== st[k].rdy) begin
            n_fail++;
            $display("FAIL set_clr[%0d] ready got %b want %b",
                     k, ifc.instr_ready, st[k].rdy);
         end
         if (st[k].v && st[k].rdy) exp_q.push_back(st[k].e);
         tick();
         e = exp_q.size() != 0 ? exp_q.pop_front() : BUB;
         n_run++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL set_clr[%0d] out got %h want %h", k, obs(), e);
         end
      end
   endtask

   task automatic test_back_to_back();
      step_t st [$];
      out_t e;
      do_reset();
      for (int i = 0; i < 4; i++)
         st.push_back(S(0, 16'h0000, 1, 3'(i), 8'hA0 + 8'(i), 1, BUB));
      for (int i = 0; i < 4; i++)
         st.push_back(S(1, mk(5'b10001, 3'(i), 8'(i * 17)), 0, 3'd0,
                        8'h00, 1,
                        ex(8'hA0 + 8'(i), 8'(i * 17), 5'b10001, 3'(i))));
      foreach (st[k]) begin
         drive(st[k].v, st[k].i, st[k].we, st[k].wa, st[k].wd);
         n_run++;
         if (ifc.instr_ready !== st[k].rdy) begin
            n_fail++;
            $display("FAIL b2b[%0d] ready got %b want %b",
                     k, ifc.instr_ready, st[k].rdy);
         end
         if (st[k].v && st[k].rdy) exp_q.push_back(st[k].e);
         tick();
         e = exp_q.size() != 0 ? exp_q.pop_front() : BUB;
         n_run++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL b2b[%0d] out got %h want %h", k, obs(), e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_wb_read();
      test_imm();
      test_raw();
      test_store();
      test_set_clear();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
